eth_type_demux: RTL and testbench
=================================

// Module: eth_type_demux
// PURPOSE
//  Parametrised EtherType classifier/demux for the receive side of the stack: routes each eth frame (header + AXI-S payload)
//  to one of M_COUNT output channels by table match on s_eth_type, or drops it. Successor to the fixed IP/ARP input split:
//  N channels, any data width, per-channel enable, header-handshake-based selection, unmatched-frame drop counter.
// PARAMETERS
//  M_COUNT       2                 number of output channels
//  DATA_WIDTH    8                 payload tdata width
//  KEEP_ENABLE   (DATA_WIDTH>8)    tkeep present
//  KEEP_WIDTH    (DATA_WIDTH/8)    tkeep width
//  USER_WIDTH    1                 tuser width
//  ETH_TYPES     {16'h0800,16'h0806}  M_COUNT*16 packed match table, bits[15:0] = channel 0
//  COUNT_WIDTH   32                drop counter width
// PORTS
//  clk                      in   1              clock
//  rst                      in   1              async reset, active-high
//  s_eth_hdr_valid/ready    in/out 1            input header handshake
//  s_eth_dest_mac/src_mac   in   48             header fields
//  s_eth_type               in   16             EtherType
//  s_eth_payload_axis_t{data,keep,valid,ready,last,user}  in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH
//  m_eth_hdr_valid          out  M_COUNT        per-channel header valid
//  m_eth_hdr_ready          in   M_COUNT        per-channel header ready
//  m_eth_dest_mac/src_mac   out  48             shared header fields (registered)
//  m_eth_type               out  16             shared registered type
//  m_eth_payload_axis_tvalid out M_COUNT        per-channel payload valid
//  m_eth_payload_axis_tready in  M_COUNT        per-channel payload ready
//  m_eth_payload_axis_t{data,keep,last,user} out  shared, combinational pass-through
//  channel_enable           in   M_COUNT        1 = channel may match
//  drop_count               out  COUNT_WIDTH    unmatched frames, saturating
//  busy                     out  1              state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, m_eth_hdr_valid=0, header regs=0, drop_count=0, sel=0; all tvalid/tready outputs 0.
//  - FSM IDLE/ACTIVE/DROP. s_eth_hdr_ready = (state==IDLE) && !(|m_eth_hdr_valid).
//  - Header accept (valid&&ready): sel = lowest i with ETH_TYPES[i]==s_eth_type && channel_enable[i]; enable sampled only here.
//    Match: next cycle m_eth_hdr_valid[sel]=1 with registered fields (1-cycle latency); held until m_eth_hdr_ready[sel]; -> ACTIVE.
//    No match: no header out; drop_count+1 (holds at all-ones); -> DROP.
//  - ACTIVE: m_tvalid[sel]=s_tvalid, s_tready=m_tready[sel], other channels' tvalid=0; data/keep/last/user pass through 0 latency.
//    Payload may flow before header consumed. tlast transfer -> IDLE.
//  - DROP: s_tready=1, all m_tvalid=0; tlast transfer -> IDLE.
//  - IDLE: s_tready=0 (payload before header stalls).
//  - Next header blocked until prior output header consumed, even if payload finished; no same-cycle tlast+header overlap.
//  - Duplicate ETH_TYPES entries: lowest index wins. tuser (error) forwarded unchanged, no drop decision on it.
//  - Reset mid-frame: immediate IDLE, frame truncated; upstream reset together with this block.
//  - KEEP_ENABLE=0: tkeep driven all-ones.
// STRUCTURE
//  - Shared header eth_types.vh: ETH_TYPE_IPV4=16'h0800, ETH_TYPE_ARP=16'h0806, ETH_TYPE_IPV6=16'h86DD, ETH_TYPE_VLAN=16'h8100.
//  - Sub-module eth_type_match: combinational priority compare (type, table, enable) -> {match, index}.
//  - Top: FSM, header output register, payload routing mux, drop counter.
// TESTING
//  1 type 0x0800, enable=2'b11 -> hdr valid on ch1 1 cycle after accept, payload 64 B all on ch1, ch0 tvalid=0, busy low after tlast.
//  2 type 0x86DD -> no m_eth_hdr_valid, s_tready=1 whole frame, drop_count 0->1; 3 such frames -> 3.
//  3 type 0x0806 with enable=2'b10 -> dropped, drop_count+1; same frame with 2'b11 -> ch0.
//  4 m_eth_hdr_ready[1] held low 20 cycles while payload completes -> s_eth_hdr_ready stays 0 until header taken; next frame ok.
//  5 random m_tready backpressure, back-to-back mixed 0x0800/0x0806 frames -> byte-exact, order-preserving per channel.
//  6 rst asserted mid-payload -> outputs 0 same cycle, drop_count=0; COUNT_WIDTH=2, 5 drops -> drop_count=3.

Source files
------------

// File: rtl/eth_type_demux_pkg.sv
`default_nettype none
// ============================================================================
// eth_type_demux_pkg : EtherType constants and demux state encoding
// Rev 1.0
// ============================================================================
package eth_type_demux_pkg;

  localparam logic [15:0] c_eth_type_ipv4 = 16'h0800;
  localparam logic [15:0] c_eth_type_arp  = 16'h0806;
  localparam logic [15:0] c_eth_type_ipv6 = 16'h86DD;
  localparam logic [15:0] c_eth_type_vlan = 16'h8100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } demux_state_t;

  // Channel index width, kept at least 1 bit for a single-channel build
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_type_match.sv
`default_nettype none
// ============================================================================
// eth_type_match : priority compare of an EtherType against the channel table
// Rev 1.0
// ============================================================================
module eth_type_match
  import eth_type_demux_pkg::*;
#(
  parameter int M_COUNT = 2,
  parameter int IDX_W   = idx_width(M_COUNT)
) (
  input  logic [15:0]           eth_type,
  input  logic [M_COUNT*16-1:0] eth_types,
  input  logic [M_COUNT-1:0]    channel_enable,
  output logic                  match,
  output logic [IDX_W-1:0]      index
);

  // Scan high to low so the lowest matching index is the one left standing
  always_comb begin
    match = 1'b0;
    index = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (channel_enable[i] && (eth_types[i*16 +: 16] == eth_type)) begin
        match = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_type_demux.sv
`default_nettype none
// ============================================================================
// eth_type_demux : routes eth frames to M_COUNT channels by EtherType, or drops
// Rev 1.0
// ============================================================================
module eth_type_demux
  import eth_type_demux_pkg::*;
#(
  parameter int                    M_COUNT     = 2,
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int                    USER_WIDTH  = 1,
  parameter logic [M_COUNT*16-1:0] ETH_TYPES   = {c_eth_type_ipv4, c_eth_type_arp},
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [47:0]            s_eth_src_mac,
  input  logic [15:0]            s_eth_type,
  input  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_eth_payload_axis_tkeep,
  input  logic                   s_eth_payload_axis_tvalid,
  output logic                   s_eth_payload_axis_tready,
  input  logic                   s_eth_payload_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_eth_payload_axis_tuser,
  output logic [M_COUNT-1:0]     m_eth_hdr_valid,
  input  logic [M_COUNT-1:0]     m_eth_hdr_ready,
  output logic [47:0]            m_eth_dest_mac,
  output logic [47:0]            m_eth_src_mac,
  output logic [15:0]            m_eth_type,
  output logic [DATA_WIDTH-1:0]  m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_eth_payload_axis_tkeep,
  output logic [M_COUNT-1:0]     m_eth_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]     m_eth_payload_axis_tready,
  output logic                   m_eth_payload_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_eth_payload_axis_tuser,
  input  logic [M_COUNT-1:0]     channel_enable,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic                   busy
);

  localparam int IDX_W = idx_width(M_COUNT);

  demux_state_t           r_state;
  logic [IDX_W-1:0]       r_sel;
  logic [M_COUNT-1:0]     r_hdr_valid;
  logic [47:0]            r_dest_mac;
  logic [47:0]            r_src_mac;
  logic [15:0]            r_eth_type;
  logic [COUNT_WIDTH-1:0] r_drop_count;

  logic                   w_match;
  logic [IDX_W-1:0]       w_match_idx;
  logic [M_COUNT-1:0]     w_match_onehot;
  logic                   w_hdr_ready;
  logic                   w_hdr_accept;
  logic                   w_s_tready;
  logic [M_COUNT-1:0]     w_m_tvalid;
  logic                   w_last_xfer;

  eth_type_match #(
    .M_COUNT (M_COUNT),
    .IDX_W   (IDX_W)
  ) u_match (
    .eth_type       (s_eth_type),
    .eth_types      (ETH_TYPES),
    .channel_enable (channel_enable),
    .match          (w_match),
    .index          (w_match_idx)
  );

  always_comb begin
    w_match_onehot = '0;
    w_match_onehot[w_match_idx] = 1'b1;
  end

  // A new header waits until the previous output header has been taken
  assign w_hdr_ready  = (r_state == ST_IDLE) && !(|r_hdr_valid);
  assign w_hdr_accept = s_eth_hdr_valid && w_hdr_ready;

  always_comb begin
    w_m_tvalid = '0;
    w_s_tready = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        w_m_tvalid[r_sel] = s_eth_payload_axis_tvalid;
        w_s_tready        = m_eth_payload_axis_tready[r_sel];
      end
      ST_DROP: w_s_tready = 1'b1;
      default: w_s_tready = 1'b0;
    endcase
  end

  assign w_last_xfer = s_eth_payload_axis_tvalid && w_s_tready && s_eth_payload_axis_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_hdr_valid  <= '0;
      r_dest_mac   <= '0;
      r_src_mac    <= '0;
      r_eth_type   <= '0;
      r_drop_count <= '0;
    end else begin
      r_hdr_valid <= r_hdr_valid & ~m_eth_hdr_ready;
      case (r_state)
        ST_IDLE: begin
          if (w_hdr_accept) begin
            if (w_match) begin
              r_hdr_valid <= w_match_onehot;
              r_sel       <= w_match_idx;
              r_dest_mac  <= s_eth_dest_mac;
              r_src_mac   <= s_eth_src_mac;
              r_eth_type  <= s_eth_type;
              r_state     <= ST_ACTIVE;
            end else begin
              if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
              end
              r_state <= ST_DROP;
            end
          end
        end
        ST_ACTIVE, ST_DROP: begin
          if (w_last_xfer) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (KEEP_ENABLE) begin : g_keep
      assign m_eth_payload_axis_tkeep = s_eth_payload_axis_tkeep;
    end else begin : g_no_keep
      logic w_unused_keep;
      assign w_unused_keep            = ^s_eth_payload_axis_tkeep;
      assign m_eth_payload_axis_tkeep = '1;
    end
  endgenerate

  assign s_eth_hdr_ready           = w_hdr_ready;
  assign s_eth_payload_axis_tready = w_s_tready;
  assign m_eth_hdr_valid           = r_hdr_valid;
  assign m_eth_dest_mac            = r_dest_mac;
  assign m_eth_src_mac             = r_src_mac;
  assign m_eth_type                = r_eth_type;
  assign m_eth_payload_axis_tvalid = w_m_tvalid;
  assign m_eth_payload_axis_tdata  = s_eth_payload_axis_tdata;
  assign m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast;
  assign m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser;
  assign drop_count                = r_drop_count;
  assign busy                      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_type_demux.sv
`default_nettype none
// tb_eth_type_demux : directed bench, ch0 = ARP (0x0806), ch1 = IPv4 (0x0800)
module tb_eth_type_demux;
  import eth_type_demux_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_hdr_valid = 1'b0;
  logic [47:0] s_dest = '0;
  logic [47:0] s_src = '0;
  logic [15:0] s_type = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tkeep = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [1:0]  m_hdr_ready = 2'b11;
  logic [1:0]  m_tready = 2'b11;
  logic [1:0]  chan_en = 2'b11;
  logic        bp_en = 1'b0;

  logic        s_hdr_ready, s_tready, m_tkeep, m_tlast, m_tuser, busy;
  logic [1:0]  m_hdr_valid, m_tvalid;
  logic [47:0] m_dest, m_src;
  logic [15:0] m_type;
  logic [7:0]  m_tdata;
  logic [31:0] drop_count;

  logic        d2_unused_hdr_ready, d2_unused_tready, d2_unused_tkeep, d2_unused_tlast;
  logic        d2_unused_tuser, d2_unused_busy;
  logic [1:0]  d2_unused_hdr_valid, d2_unused_tvalid;
  logic [47:0] d2_unused_dest, d2_unused_src;
  logic [15:0] d2_unused_type;
  logic [7:0]  d2_unused_tdata;
  logic [1:0]  d2_drop;

  always #5 clk = ~clk;

  eth_type_demux dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .channel_enable(chan_en), .drop_count(drop_count), .busy(busy)
  );

  // Narrow-counter build fed the same traffic, to see the counter saturate
  eth_type_demux #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(d2_unused_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(d2_unused_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(d2_unused_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(d2_unused_dest), .m_eth_src_mac(d2_unused_src), .m_eth_type(d2_unused_type),
    .m_eth_payload_axis_tdata(d2_unused_tdata), .m_eth_payload_axis_tkeep(d2_unused_tkeep),
    .m_eth_payload_axis_tvalid(d2_unused_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(d2_unused_tlast), .m_eth_payload_axis_tuser(d2_unused_tuser),
    .channel_enable(chan_en), .drop_count(d2_drop), .busy(d2_unused_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx0[$], rx1[$], exp0[$], exp1[$];
  int ch0_valid_cnt = 0, any_valid_cnt = 0, both_cnt = 0;
  int hdr_cnt0 = 0, hdr_cnt1 = 0, user_cnt = 0, last_cnt1 = 0;
  int p0 = 0, p1 = 0;

  always @(negedge clk) begin
    if (m_tvalid[0] && m_tready[0]) rx0.push_back(m_tdata);
    if (m_tvalid[1] && m_tready[1]) rx1.push_back(m_tdata);
    if (m_tvalid[1] && m_tready[1] && m_tlast) last_cnt1++;
    if (|(m_tvalid & m_tready) && m_tuser) user_cnt++;
    if (m_tvalid[0]) ch0_valid_cnt++;
    if (|m_tvalid) any_valid_cnt++;
    if (&m_tvalid) both_cnt++;
    if (m_hdr_valid[0] && m_hdr_ready[0]) hdr_cnt0++;
    if (m_hdr_valid[1] && m_hdr_ready[1]) hdr_cnt1++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? 2'($urandom_range(0, 3)) : 2'b11;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [15:0] t, input int len, input logic [7:0] base,
                            input logic [1:0] exp_hdr, input logic err, output int stalls);
    int w;
    int timeouts;
    stalls   = 0;
    timeouts = 0;
    @(posedge clk); #1;
    s_hdr_valid = 1'b1;
    s_type      = t;
    s_dest      = {32'h0a0b0c0d, base, 8'h01};
    s_src       = {40'h1112131415, base};
    w = 0;
    @(negedge clk);
    while (!s_hdr_ready && w < 200) begin @(negedge clk); w++; end
    check("hdr_accept", s_hdr_ready, 1);
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
    #1;
    check("hdr_valid", m_hdr_valid, exp_hdr);
    check("busy_on", busy, 1);
    if (exp_hdr != 2'b00) begin
      check("m_type", m_type, t);
      check("m_dest", m_dest, {32'h0a0b0c0d, base, 8'h01});
      check("m_src", m_src, {40'h1112131415, base});
    end
    for (int b = 0; b < len; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 8'(b);
      s_tlast  = (b == len - 1);
      s_tuser  = err && (b == len - 1);
      if (exp_hdr == 2'b01) exp0.push_back(s_tdata);
      else if (exp_hdr == 2'b10) exp1.push_back(s_tdata);
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 200) begin @(negedge clk); w++; end
      stalls += w;
      if (!s_tready) timeouts++;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    check("pay_timeout", timeouts, 0);
    #1;
    check("busy_off", busy, 0);
  endtask

  task automatic check_rx(input string tag);
    int bad;
    check({tag, "_n0"}, rx0.size(), exp0.size());
    check({tag, "_n1"}, rx1.size(), exp1.size());
    bad = 0;
    for (int k = p0; k < exp0.size(); k++) if (k >= rx0.size() || rx0[k] !== exp0[k]) bad++;
    for (int k = p1; k < exp1.size(); k++) if (k >= rx1.size() || rx1[k] !== exp1[k]) bad++;
    check({tag, "_data"}, bad, 0);
    p0 = exp0.size();
    p1 = exp1.size();
  endtask

  initial begin
    int st, b_ch0, b_any, b_both, b_h0, b_h1, b_user, b_last;

    // reset state, with payload offered to show it is not accepted
    s_tvalid = 1'b1;
    #12;
    check("rst_hdr_valid", m_hdr_valid, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_type", m_type, 0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: IPv4 to ch1, 64 bytes, error flag on last byte
    b_ch0 = ch0_valid_cnt; b_h1 = hdr_cnt1; b_user = user_cnt; b_last = last_cnt1;
    send_frame(c_eth_type_ipv4, 64, 8'h00, 2'b10, 1'b1, st);
    check("t1_ch0_valid", ch0_valid_cnt - b_ch0, 0);
    check("t1_hdr_taken", hdr_cnt1 - b_h1, 1);
    check("t1_tuser", user_cnt - b_user, 1);
    check("t1_tlast", last_cnt1 - b_last, 1);
    check("t1_tkeep", m_tkeep, 1);
    check_rx("t1");

    // 2: three unmatched IPv6 frames
    b_any = any_valid_cnt;
    send_frame(c_eth_type_ipv6, 10, 8'h40, 2'b00, 1'b0, st);
    check("t2_stall", st, 0);
    check("t2_drop1", drop_count, 1);
    send_frame(c_eth_type_ipv6, 3, 8'h50, 2'b00, 1'b0, st);
    check("t2_drop2", drop_count, 2);
    send_frame(c_eth_type_ipv6, 1, 8'h58, 2'b00, 1'b0, st);
    check("t2_drop3", drop_count, 3);
    check("t2_no_tvalid", any_valid_cnt - b_any, 0);
    check_rx("t2");

    // 3: ARP with ch0 disabled drops; re-enabled goes to ch0
    chan_en = 2'b10;
    send_frame(c_eth_type_arp, 5, 8'h60, 2'b00, 1'b0, st);
    check("t3_drop", drop_count, 4);
    chan_en = 2'b11;
    b_h0 = hdr_cnt0;
    send_frame(c_eth_type_arp, 5, 8'h60, 2'b01, 1'b0, st);
    check("t3_hdr_ch0", hdr_cnt0 - b_h0, 1);
    check("t3_drop_hold", drop_count, 4);
    check_rx("t3");

    // 4: ch1 header held back while its payload completes
    m_hdr_ready = 2'b01;
    send_frame(c_eth_type_ipv4, 8, 8'h70, 2'b10, 1'b0, st);
    repeat (20) @(posedge clk);
    #1;
    check("t4_hdr_blocked", s_hdr_ready, 0);
    check("t4_hdr_held", m_hdr_valid, 2'b10);
    check("t4_idle", busy, 0);
    m_hdr_ready = 2'b11;
    @(posedge clk); #1;
    check("t4_hdr_free", s_hdr_ready, 1);
    check("t4_hdr_clear", m_hdr_valid, 0);
    send_frame(c_eth_type_arp, 4, 8'h80, 2'b01, 1'b0, st);
    check_rx("t4");

    // 5: back-to-back mixed frames under random backpressure
    bp_en = 1'b1;
    b_both = both_cnt; b_h0 = hdr_cnt0; b_h1 = hdr_cnt1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send_frame(c_eth_type_ipv4, 1 + (i * 3) % 7, 8'(8'h90 + i * 8), 2'b10, 1'b0, st);
      else            send_frame(c_eth_type_arp,  1 + (i * 3) % 7, 8'(8'h90 + i * 8), 2'b01, 1'b0, st);
    end
    bp_en = 1'b0;
    check("t5_both_valid", both_cnt - b_both, 0);
    check("t5_hdr_ch0", hdr_cnt0 - b_h0, 4);
    check("t5_hdr_ch1", hdr_cnt1 - b_h1, 4);
    check_rx("t5");

    // 6: fifth drop saturates the 2-bit counter, then reset mid-payload
    send_frame(c_eth_type_vlan, 3, 8'hb0, 2'b00, 1'b0, st);
    check("t6_drop5", drop_count, 5);
    check("t6_drop_sat", d2_drop, 3);
    @(posedge clk); #1;
    s_hdr_valid = 1'b1;
    s_type      = c_eth_type_ipv4;
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'hc0 + 8'(b);
      exp1.push_back(s_tdata);
      @(posedge clk); #1;
    end
    s_tdata = 8'hc3;
    rst     = 1'b1;
    #1;
    check("t6_rst_tvalid", m_tvalid, 0);
    check("t6_rst_tready", s_tready, 0);
    check("t6_rst_hdr", m_hdr_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_drop", drop_count, 0);
    check("t6_rst_drop2", d2_drop, 0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(c_eth_type_ipv4, 4, 8'hd0, 2'b10, 1'b0, st);
    check_rx("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
